// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the two-master data-memory arbiter.
package dm_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes to i_prio.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_gnt
);

  // NOTE: o_gnt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_prio ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the single-port data memory: round-robin with burst lock,
// MAX_HOLD anti-starvation and a registered ack/read-data return one cycle after acceptance.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e       r_state, w_state_nxt;
  logic             r_prio, w_prio_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;

  logic [1:0]  w_req, w_rr_gnt, w_gnt;
  logic        w_at_limit, w_keep0, w_keep1;
  logic        w_sel1, w_any, w_lock;
  arb_state_e  w_own;

  assign w_req      = {m1_req, m0_req};
  assign w_at_limit = (r_hold_cnt >= CNT_W'(MAX_HOLD));
  assign w_keep0    = (r_state == ST_OWN0) && m0_req && !(w_at_limit && m1_req);
  assign w_keep1    = (r_state == ST_OWN1) && m1_req && !(w_at_limit && m0_req);

  rr_pick2 u_rr (
    .i_req  (w_req),
    .i_prio (r_prio),
    .o_gnt  (w_rr_gnt)
  );

  // An owner keeps the bus until it drops req or hits the hold limit with the other waiting.
  always_comb begin
    w_gnt = w_rr_gnt;
    if (w_keep0)      w_gnt = 2'b01;
    else if (w_keep1) w_gnt = 2'b10;
    if (!rst_n)       w_gnt = 2'b00;
  end

  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];
  assign w_sel1 = w_gnt[1];
  assign w_any  = |w_gnt;
  assign w_lock = w_sel1 ? m1_lock : m0_lock;
  assign w_own  = w_sel1 ? ST_OWN1 : ST_OWN0;

  assign mem_we    = (w_gnt[0] & m0_we) | (w_gnt[1] & m1_we);
  assign mem_addr  = w_gnt[1] ? m1_addr  : (w_gnt[0] ? m0_addr  : '0);
  assign mem_wdata = w_gnt[1] ? m1_wdata : (w_gnt[0] ? m0_wdata : '0);

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_hold_nxt  = r_hold_cnt;
    if (w_any) begin
      w_prio_nxt = ~w_sel1;
      if (w_lock) begin
        w_state_nxt = w_own;
        if (r_state == w_own)
          w_hold_nxt = w_at_limit ? r_hold_cnt : r_hold_cnt + CNT_W'(1);
        else
          w_hold_nxt = CNT_W'(1);
      end else begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
      end
    end else if ((r_state == ST_OWN0 && !m0_req) || (r_state == ST_OWN1 && !m1_req)) begin
      w_state_nxt = ST_IDLE;
      w_hold_nxt  = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_prio     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= w_gnt[0];
      m1_ack <= w_gnt[1];
      if (w_gnt[0] && !m0_we) m0_rdata <= mem_rdata;
      if (w_gnt[1] && !m1_we) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic
// compared against an owner/burst/preference reference model and a shadow memory.
module tb_dm_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          m_owner;
  int          m_burst;
  int          m_pref;
  logic [31:0] m_rdata0, m_rdata1;
  logic [31:0] ref_mem [0:1023];

  typedef struct packed {
    logic [1:0]  gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  ack;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
  } obs_t;

  always #5 clk = ~clk;

  dm_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: combinational read, write on the rising edge; ld_* is a bench preload port.
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) begin
    if (ld_en)       mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  end

  function automatic int model_pick(input logic [1:0] req);
    if (m_owner >= 0 && req[m_owner] && !(m_burst >= MAX_HOLD && req[1 - m_owner]))
      return m_owner;
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    if (req == 2'b11) return m_pref;
    return -1;
  endfunction

  function automatic void model_edge(input int g, input logic [1:0] req, input logic [1:0] we,
                                     input logic [1:0] lock, input logic [31:0] a0,
                                     input logic [31:0] d0, input logic [31:0] a1,
                                     input logic [31:0] d1);
    if (g == 0) begin
      if (we[0]) ref_mem[a0[9:0]] = d0;
      else       m_rdata0 = ref_mem[a0[9:0]];
    end else if (g == 1) begin
      if (we[1]) ref_mem[a1[9:0]] = d1;
      else       m_rdata1 = ref_mem[a1[9:0]];
    end
    if (g >= 0) begin
      m_pref = 1 - g;
      if (lock[g]) begin
        m_burst = (m_owner == g) ? ((m_burst < MAX_HOLD) ? m_burst + 1 : MAX_HOLD) : 1;
        m_owner = g;
      end else begin
        m_owner = -1;
        m_burst = 0;
      end
    end else if (m_owner >= 0 && !req[m_owner]) begin
      m_owner = -1;
      m_burst = 0;
    end
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_burst  = 0;
    m_pref   = 0;
    m_rdata0 = '0;
    m_rdata1 = '0;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Writes one word into both the bench memory and the shadow copy; no requests this cycle.
  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    idle_inputs();
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    model_edge(-1, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    ref_mem[a] = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Drives one cycle starting just after a rising edge; grant/mem sampled at the falling
  // edge, ack/rdata sampled just after the next rising edge.
  task automatic beat(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic [31:0] a1, input logic [31:0] d1,
                      output obs_t obs, output obs_t exp);
    int g;
    m0_req = req[0]; m0_we = we[0]; m0_lock = lock[0]; m0_addr = a0; m0_wdata = d0;
    m1_req = req[1]; m1_we = we[1]; m1_lock = lock[1]; m1_addr = a1; m1_wdata = d1;
    g   = model_pick(req);
    exp = '0;
    if (g == 0) begin
      exp.gnt = 2'b01; exp.mem_we = we[0]; exp.mem_addr = a0; exp.mem_wdata = d0;
    end else if (g == 1) begin
      exp.gnt = 2'b10; exp.mem_we = we[1]; exp.mem_addr = a1; exp.mem_wdata = d1;
    end
    #4;
    obs           = '0;
    obs.gnt       = {m1_gnt, m0_gnt};
    obs.mem_we    = mem_we;
    obs.mem_addr  = mem_addr;
    obs.mem_wdata = mem_wdata;
    model_edge(g, req, we, lock, a0, d0, a1, d1);
    exp.ack    = (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00);
    exp.rdata0 = m_rdata0;
    exp.rdata1 = m_rdata1;
    @(posedge clk);
    #1;
    obs.ack    = {m1_ack, m0_ack};
    obs.rdata0 = m0_rdata;
    obs.rdata1 = m1_rdata;
  endtask

  task automatic test_reset();
    obs_t o, e;
    idle_inputs();
    rst_n = 1'b0;
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    #3;
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_we, m0_ack, m1_ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {m0_gnt, m1_gnt, mem_we, m0_ack, m1_ack});
    end
    do_reset();
    beat(2'b00, 2'b00, 2'b00, 32'h10, 32'h1, 32'h20, 32'h2, o, e);
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", o, e);
    end
    n_checks++;
    if ({o.rdata0, o.rdata1} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h %h expected 0 0", o.rdata0, o.rdata1);
    end
  endtask

  task automatic test_single_read();
    obs_t o, e;
    preload(10'd5, 32'h0000_A5A5);
    beat(2'b01, 2'b00, 2'b00, 32'd5, 32'h0, 32'h0, 32'h0, o, e);
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL single_read: got %h expected %h", o, e);
    end
    n_checks++;
    if ({o.gnt, o.ack, o.rdata0} !== {2'b01, 2'b01, 32'h0000_A5A5}) begin
      n_fail++;
      $display("FAIL single_read_value: got gnt=%b ack=%b rdata=%h expected 01 01 0000a5a5",
               o.gnt, o.ack, o.rdata0);
    end
  endtask

  task automatic test_round_robin();
    obs_t o, e;
    logic [31:0] a0_seq [4] = '{32'd5, 32'd6, 32'h20, 32'd7};
    logic [7:0]  gnt_seq = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat(2'b11, 2'b10, 2'b00, a0_seq[i], 32'h0, 32'h20, 32'h11, o, e);
      gnt_seq = {gnt_seq[5:0], o.gnt};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL round_robin beat %0d: got %h expected %h", i, o, e);
      end
    end
    n_checks++;
    if (gnt_seq !== 8'b01_10_01_10) begin
      n_fail++;
      $display("FAIL rr_order: got %b expected 01100110", gnt_seq);
    end
    n_checks++;
    if (mem[32'h20] !== 32'h11) begin
      n_fail++;
      $display("FAIL rr_m1_write: got %h expected 00000011", mem[32'h20]);
    end
  endtask

  task automatic test_max_hold();
    obs_t o, e;
    int   m0_run = 0;
    logic m1_seen = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      beat(2'b11, 2'b00, 2'b01, 32'(i), 32'h0, 32'd9, 32'h0, o, e);
      if (o.gnt[0] && !m1_seen) m0_run++;
      if (o.gnt[1]) m1_seen = 1'b1;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL max_hold beat %0d: got %h expected %h", i, o, e);
      end
    end
    n_checks++;
    if (m0_run !== MAX_HOLD || !m1_seen) begin
      n_fail++;
      $display("FAIL max_hold_count: got m0_run=%0d m1_seen=%b expected %0d 1", m0_run, m1_seen,
               MAX_HOLD);
    end
  endtask

  task automatic test_lock_drop();
    obs_t o, e;
    do_reset();
    beat(2'b01, 2'b00, 2'b01, 32'd1, 32'h0, 32'h0, 32'h0, o, e);
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL lock_drop_first: got %h expected %h", o, e);
    end
    beat(2'b10, 2'b00, 2'b00, 32'd1, 32'h0, 32'd2, 32'h0, o, e);
    n_checks++;
    if (o !== e || o.gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_drop_m1: got %h expected %h", o, e);
    end
  endtask

  task automatic test_reset_mid_burst();
    obs_t o, e;
    do_reset();
    preload(10'd40, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      beat(2'b01, 2'b01, 2'b01, 32'(8 + i), 32'(100 + i), 32'h0, 32'h0, o, e);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL burst beat %0d: got %h expected %h", i, o, e);
      end
    end
    m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 32'd40; m0_wdata = 32'hDEAD_BEEF;
    m1_req = 1; m1_we = 1; m1_addr = 32'd40; m1_wdata = 32'hBAD0_BAD0;
    rst_n = 1'b0;
    #4;
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_we, m0_ack, m1_ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b expected 00000",
               {m0_gnt, m1_gnt, mem_we, m0_ack, m1_ack});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (mem[40] !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL mid_reset_no_write: got %h expected 00001234", mem[40]);
    end
    rst_n = 1'b1;
    model_reset();
    beat(2'b11, 2'b01, 2'b00, 32'd40, 32'hDEAD_BEEF, 32'd41, 32'h0, o, e);
    n_checks++;
    if (o !== e || o.gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_reset_regrant: got %h expected %h", o, e);
    end
  endtask

  task automatic test_raw();
    obs_t o, e;
    beat(2'b10, 2'b10, 2'b00, 32'h0, 32'h0, 32'd3, 32'h77, o, e);
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL raw_write: got %h expected %h", o, e);
    end
    beat(2'b01, 2'b00, 2'b00, 32'd3, 32'h0, 32'h0, 32'h0, o, e);
    n_checks++;
    if (o !== e || o.rdata0 !== 32'h77) begin
      n_fail++;
      $display("FAIL raw_read: got rdata0=%h expected 00000077", o.rdata0);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [1:0] req, we, lock;
    do_reset();
    for (int a = 0; a < 16; a++) preload(10'(a), $urandom);
    for (int i = 0; i < 400; i++) begin
      req  = 2'($urandom_range(0, 3));
      we   = 2'($urandom_range(0, 3));
      lock = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      beat(req, we, lock, 32'($urandom_range(0, 15)), $urandom,
           32'($urandom_range(0, 15)), $urandom, o, e);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random beat %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_max_hold();
    test_lock_drop();
    test_reset_mid_burst();
    test_raw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
